mod_exp_ctrl: RTL and testbench

Sequencing master for the `mon_prod` Montgomery multiplier. It computes a modular exponentiation by issuing a chain of Montgomery products (square / multiply / final domain conversion) over the start/stop interface, then presents the ordinary-domain result. The Montgomery core is external: this block drives `start`/`A`/`B`/`M`/`num_words` and consumes `stop`/`P`.

---
 rtl/mod_exp_ctrl.sv | 208 ++++++++++++++++++++
 tb/tb_mod_exp_ctrl.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mod_exp_ctrl.sv
// Modular exponentiation sequencer driving an external mon_prod Montgomery core.
// Optional MOD_EXP_SKIP_LZ_EN: skip leading-zero exponent bits.
module mod_exp_ctrl #(
    parameter int unsigned bitLen     = 64,
    parameter int unsigned expLen     = 64,
    parameter int unsigned countWidth = 5,
    parameter int unsigned idxWidth   = 6
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [bitLen-1:0]     Mbar,
    input  logic [bitLen-1:0]     Xbar,
    input  logic [expLen-1:0]     E,
    input  logic [bitLen-1:0]     M,
    input  logic [countWidth-1:0] num_words,
    output logic                  busy,
    output logic                  done,
    output logic [bitLen-1:0]     result,
    output logic                  mp_start,
    output logic [bitLen-1:0]     mp_A,
    output logic [bitLen-1:0]     mp_B,
    output logic [bitLen-1:0]     mp_M,
    output logic [countWidth-1:0] mp_num_words,
    input  logic                  mp_stop,
    input  logic [bitLen-1:0]     mp_P
);

    localparam logic [2:0] IDLE = 3'd0;
    localparam logic [2:0] SQR  = 3'd1;
    localparam logic [2:0] MUL  = 3'd2;
    localparam logic [2:0] CONV = 3'd3;
    localparam logic [2:0] FIN  = 3'd4;

    localparam logic PH_REQ = 1'b0;
    localparam logic PH_REL = 1'b1;

    localparam logic [bitLen-1:0]   One     = bitLen'(1);
    localparam logic [idxWidth-1:0] LastIdx = idxWidth'(expLen - 1);

    logic [2:0]            state_q, state_d;
    logic                  phase_q, phase_d;
    logic [bitLen-1:0]     acc_q, acc_d;
    logic [bitLen-1:0]     xbar_q, xbar_d;
    logic [expLen-1:0]     e_q, e_d;
    logic [bitLen-1:0]     m_q, m_d;
    logic [countWidth-1:0] nw_q, nw_d;
    logic [idxWidth-1:0]   idx_q, idx_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic [bitLen-1:0]     result_q, result_d;
    logic                  mp_start_q, mp_start_d;
    logic [bitLen-1:0]     mp_a_q, mp_a_d;
    logic [bitLen-1:0]     mp_b_q, mp_b_d;
    logic                  bit_set;

`ifdef MOD_EXP_SKIP_LZ_EN
    logic [idxWidth-1:0] e_msb;
    logic                e_nz;

    always_comb begin
        e_msb = '0;
        e_nz  = |E;
        for (int unsigned i = 0; i < expLen; i++) begin
            if (E[i]) e_msb = idxWidth'(i);
        end
    end
`endif

    assign bit_set = e_q[idx_q];

    always_comb begin
        state_d    = state_q;
        phase_d    = phase_q;
        acc_d      = acc_q;
        xbar_d     = xbar_q;
        e_d        = e_q;
        m_d        = m_q;
        nw_d       = nw_q;
        idx_d      = idx_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        result_d   = result_q;
        mp_start_d = mp_start_q;
        mp_a_d     = mp_a_q;
        mp_b_d     = mp_b_q;

        case (state_q)
            IDLE: begin
                // The core is not reset with us, so wait until it has released stop.
                if (start && !mp_stop) begin
                    xbar_d     = Xbar;
                    e_d        = E;
                    m_d        = M;
                    nw_d       = num_words;
                    busy_d     = 1'b1;
                    phase_d    = PH_REQ;
                    mp_start_d = 1'b1;
`ifdef MOD_EXP_SKIP_LZ_EN
                    if (!e_nz) begin
                        acc_d   = Mbar;
                        idx_d   = '0;
                        state_d = CONV;
                        mp_a_d  = Mbar;
                        mp_b_d  = One;
                    end else if (e_msb == '0) begin
                        acc_d   = Xbar;
                        idx_d   = '0;
                        state_d = CONV;
                        mp_a_d  = Xbar;
                        mp_b_d  = One;
                    end else begin
                        acc_d   = Xbar;
                        idx_d   = e_msb - idxWidth'(1);
                        state_d = SQR;
                        mp_a_d  = Xbar;
                        mp_b_d  = Xbar;
                    end
`else
                    acc_d   = Mbar;
                    idx_d   = LastIdx;
                    state_d = SQR;
                    mp_a_d  = Mbar;
                    mp_b_d  = Mbar;
`endif
                end
            end
            SQR, MUL, CONV: begin
                if (phase_q == PH_REQ) begin
                    if (mp_stop) begin
                        acc_d      = mp_P;
                        mp_start_d = 1'b0;
                        phase_d    = PH_REL;
                    end
                end else if (!mp_stop) begin
                    phase_d    = PH_REQ;
                    mp_start_d = 1'b1;
                    if (state_q == CONV) begin
                        state_d    = FIN;
                        mp_start_d = 1'b0;
                        done_d     = 1'b1;
                        busy_d     = 1'b0;
                        result_d   = acc_q;
                    end else if (state_q == SQR && bit_set) begin
                        state_d = MUL;
                        mp_a_d  = acc_q;
                        mp_b_d  = xbar_q;
                    end else if (idx_q == '0) begin
                        state_d = CONV;
                        mp_a_d  = acc_q;
                        mp_b_d  = One;
                    end else begin
                        state_d = SQR;
                        idx_d   = idx_q - idxWidth'(1);
                        mp_a_d  = acc_q;
                        mp_b_d  = acc_q;
                    end
                end
            end
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            phase_q    <= PH_REQ;
            acc_q      <= '0;
            xbar_q     <= '0;
            e_q        <= '0;
            m_q        <= '0;
            nw_q       <= '0;
            idx_q      <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            result_q   <= '0;
            mp_start_q <= 1'b0;
            mp_a_q     <= '0;
            mp_b_q     <= '0;
        end else begin
            state_q    <= state_d;
            phase_q    <= phase_d;
            acc_q      <= acc_d;
            xbar_q     <= xbar_d;
            e_q        <= e_d;
            m_q        <= m_d;
            nw_q       <= nw_d;
            idx_q      <= idx_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            result_q   <= result_d;
            mp_start_q <= mp_start_d;
            mp_a_q     <= mp_a_d;
            mp_b_q     <= mp_b_d;
        end
    end

    assign busy         = busy_q;
    assign done         = done_q;
    assign result       = result_q;
    assign mp_start     = mp_start_q;
    assign mp_A         = mp_a_q;
    assign mp_B         = mp_b_q;
    assign mp_M         = m_q;
    assign mp_num_words = nw_q;

endmodule

// File: tb/tb_mod_exp_ctrl.sv
// Directed bench for mod_exp_ctrl with a 3-cycle behavioural Montgomery core.
module tb_mod_exp_ctrl;

`ifdef MOD_EXP_SKIP_LZ_EN
    localparam int CallsE2 = 2, CallsE0 = 1, CallsE1 = 1, CallsE3 = 3, CallsE10 = 5;
`else
    localparam int CallsE2 = 66, CallsE0 = 65, CallsE1 = 66, CallsE3 = 67, CallsE10 = 67;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        start = 1'b0;
    logic [63:0] Mbar, Xbar, E, M;
    logic [4:0]  num_words;
    logic        busy, done;
    logic [63:0] result;
    logic        mp_start;
    logic [63:0] mp_A, mp_B, mp_M;
    logic [4:0]  mp_num_words;
    logic        mp_stop = 1'b0;
    logic [63:0] mp_P = '0;

    int n_tests = 0;
    int n_fail  = 0;

    mod_exp_ctrl dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .Mbar         (Mbar),
        .Xbar         (Xbar),
        .E            (E),
        .M            (M),
        .num_words    (num_words),
        .busy         (busy),
        .done         (done),
        .result       (result),
        .mp_start     (mp_start),
        .mp_A         (mp_A),
        .mp_B         (mp_B),
        .mp_M         (mp_M),
        .mp_num_words (mp_num_words),
        .mp_stop      (mp_stop),
        .mp_P         (mp_P)
    );

    always #5 clk = ~clk;

    // A*B*2^-64 mod m, by halving modulo odd m 64 times.
    function automatic logic [63:0] mont(input logic [63:0] a, input logic [63:0] b,
                                         input logic [63:0] m);
        logic [127:0] t;
        if (m == '0) return '0;
        t = (128'(a) * 128'(b)) % 128'(m);
        for (int i = 0; i < 64; i++) t = t[0] ? (t + 128'(m)) >> 1 : t >> 1;
        return t[63:0];
    endfunction

    logic [1:0] lat_cnt = '0;
    logic       hold_req = 1'b0;
    int         call_cnt = 0;

    always @(posedge clk) begin
        if (mp_stop) begin
            if (!mp_start && !hold_req) mp_stop <= 1'b0;
        end else if (mp_start) begin
            if (lat_cnt == 2'd2) begin
                mp_stop  <= 1'b1;
                mp_P     <= mont(mp_A, mp_B, mp_M);
                lat_cnt  <= '0;
                call_cnt <= call_cnt + 1;
            end else begin
                lat_cnt <= lat_cnt + 2'd1;
            end
        end
    end

    logic        prev_start = 1'b0;
    logic [63:0] prev_a = '0, prev_b = '0, prev_m = '0;
    int          start_rise_err = 0, done_start_err = 0, stab_err = 0, done_cnt = 0;

    always @(negedge clk) begin
        if (rst_n) begin
            if (mp_start && !prev_start && mp_stop) start_rise_err <= start_rise_err + 1;
            if (done && mp_start) done_start_err <= done_start_err + 1;
            if (mp_start && prev_start && (mp_A != prev_a || mp_B != prev_b || mp_M != prev_m))
                stab_err <= stab_err + 1;
            if (done) done_cnt <= done_cnt + 1;
        end
        prev_start <= mp_start;
        prev_a     <= mp_A;
        prev_b     <= mp_B;
        prev_m     <= mp_M;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic set_ops(input logic [63:0] x, input logic [63:0] e, input logic [63:0] m);
        logic [127:0] r;
        r    = (128'(1) << 64) % 128'(m);
        Mbar = r[63:0];
        r    = (128'(x) << 64) % 128'(m);
        Xbar = r[63:0];
        E    = e;
        M    = m;
    endtask

    task automatic launch(input string tag, input logic [63:0] x, input logic [63:0] e,
                          input logic [63:0] m);
        set_ops(x, e, m);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check({tag, "_busy_rise"}, busy, 1);
        check({tag, "_req_rise"}, mp_start, 1);
        check({tag, "_mp_M"}, mp_M, m);
        check({tag, "_mp_nw"}, mp_num_words, num_words);
    endtask

    task automatic wait_done(input string tag);
        int i = 0;
        while (!done && i < 5000) begin
            @(negedge clk);
            i++;
        end
        check({tag, "_done_seen"}, done, 1);
    endtask

    task automatic run_case(input string tag, input logic [63:0] x, input logic [63:0] e,
                            input logic [63:0] m, input logic [63:0] exp_res, input int exp_calls);
        int c0, d0;
        c0 = call_cnt;
        d0 = done_cnt;
        launch(tag, x, e, m);
        wait_done(tag);
        check({tag, "_result"}, result, exp_res);
        check({tag, "_busy_fall"}, busy, 0);
        @(negedge clk);
        check({tag, "_done_width"}, done, 0);
        repeat (3) @(negedge clk);
        check({tag, "_done_count"}, done_cnt - d0, 1);
        check({tag, "_calls"}, call_cnt - c0, exp_calls);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0, d0, i;
        Mbar = '0; Xbar = '0; E = '0; M = '0; num_words = 5'd2;
        #2 rst_n = 1'b0;
        #1;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_result", result, 0);
        check("rst_mp_start", mp_start, 0);
        check("rst_mp_A", mp_A, 0);
        check("rst_mp_B", mp_B, 0);
        check("rst_mp_M", mp_M, 0);
        check("rst_mp_nw", mp_num_words, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // E=2 with a start in the done cycle, which must be ignored
        c0 = call_cnt;
        d0 = done_cnt;
        launch("e2", 216, 2, 253);
        wait_done("e2");
        check("e2_result", result, 104);
        check("e2_busy_fall", busy, 0);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("e2_done_width", done, 0);
        check("fin_start_ignored", busy, 0);
        repeat (4) @(negedge clk);
        check("e2_done_count", done_cnt - d0, 1);
        check("e2_calls", call_cnt - c0, CallsE2);
        check("e2_result_held", result, 104);

        run_case("e0", 216, 0, 253, 1, CallsE0);
        run_case("e1", 123, 1, 253, 123, CallsE1);

        // start pulsed while busy must not disturb the running request
        c0 = call_cnt;
        d0 = done_cnt;
        launch("busy", 216, 3, 253);
        repeat (20) @(negedge clk);
        set_ops(5, 1, 13);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("busy_still", busy, 1);
        wait_done("busy");
        check("busy_result", result, 200);
        repeat (4) @(negedge clk);
        check("busy_done_count", done_cnt - d0, 1);
        check("busy_calls", call_cnt - c0, CallsE3);

        run_case("m1", 5, 3, 1, 0, CallsE3);
        run_case("e10", 7, 10, 1000003, 474403, CallsE10);

        // reset while the core holds stop high during the 10th call
        c0 = call_cnt;
        launch("rst", 216, 64'hFFFF, 253);
        i = 0;
        while (!(call_cnt - c0 == 9 && mp_start && !mp_stop) && i < 5000) begin
            @(negedge clk);
            i++;
        end
        check("rst_call10_reached", call_cnt - c0, 9);
        hold_req = 1'b1;
        i = 0;
        while (!mp_stop && i < 100) begin
            @(negedge clk);
            i++;
        end
        check("rst_stop_high", mp_stop, 1);
        rst_n = 1'b0;
        #1;
        check("mid_busy", busy, 0);
        check("mid_done", done, 0);
        check("mid_result", result, 0);
        check("mid_mp_start", mp_start, 0);
        check("mid_mp_A", mp_A, 0);
        check("mid_mp_B", mp_B, 0);
        check("mid_mp_M", mp_M, 0);
        check("mid_mp_nw", mp_num_words, 0);
        @(negedge clk);
        rst_n = 1'b1;
        set_ops(5, 2, 13);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("start_blocked_busy", busy, 0);
        check("start_blocked_stop", mp_stop, 1);
        repeat (2) @(negedge clk);
        hold_req = 1'b0;
        i = 0;
        while (mp_stop && i < 100) begin
            @(negedge clk);
            i++;
        end
        check("stop_released", mp_stop, 0);
        run_case("post_rst", 5, 2, 13, 12, CallsE2);

        check("audit_start_rise", start_rise_err, 0);
        check("audit_done_start", done_start_err, 0);
        check("audit_operand_stable", stab_err, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
